// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan capture: active-low segment
// patterns (bit0=a .. bit6=g), decoded code values, slot record and FSM states.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } cap_state_e;

    typedef struct packed {
        logic [3:0] code;
        logic       dp;
        logic       err;
    } slot_t;

    // Digit index of a one-hot-low anode pattern.
    function automatic logic [1:0] anode_idx(logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sseg_scan_capture_decode.sv
// Combinational seven-segment decoder: active-low pattern to BCD code plus
// error flag. Blank decodes to BCD_BLANK without error.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = BCD_ERR;
        err  = 1'b1;
        case (seg)
            SEG_0:     begin code = 4'd0;      err = 1'b0; end
            SEG_1:     begin code = 4'd1;      err = 1'b0; end
            SEG_2:     begin code = 4'd2;      err = 1'b0; end
            SEG_3:     begin code = 4'd3;      err = 1'b0; end
            SEG_4:     begin code = 4'd4;      err = 1'b0; end
            SEG_5:     begin code = 4'd5;      err = 1'b0; end
            SEG_6:     begin code = 4'd6;      err = 1'b0; end
            SEG_7:     begin code = 4'd7;      err = 1'b0; end
            SEG_8:     begin code = 4'd8;      err = 1'b0; end
            SEG_9:     begin code = 4'd9;      err = 1'b0; end
            SEG_BLANK: begin code = BCD_BLANK; err = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Samples a multiplexed active-low 4-digit seven-segment scan, rebuilds frames
// and publishes them once stable. Define SSEG_CAP_SYNC_EN to add a 2-flop input synchronizer.
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an_in,
    input  logic [6:0]  sseg_in,
    input  logic        dp_in,
    output logic [15:0] digits,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_err,
    output logic        frame_err,
    output logic        frame_valid,
    output logic        scan_timeout
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int STW = $clog2(STABLE_FRAMES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [11:0] raw_in, in_s;
    assign raw_in = {dp_in, sseg_in, an_in};

`ifdef SSEG_CAP_SYNC_EN
    logic [11:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
    end

    // Resets to the all-inactive pattern so nothing looks like a live digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 12'hFFF;
            sync2_q <= 12'hFFF;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = raw_in;
`endif

    logic [3:0] an_s;
    logic [6:0] seg_s;
    logic       dp_s;
    assign an_s  = in_s[3:0];
    assign seg_s = in_s[10:4];
    assign dp_s  = in_s[11];

    logic [3:0] dec_code;
    logic       dec_err;

    sseg_decode u_decode (
        .seg  (seg_s),
        .code (dec_code),
        .err  (dec_err)
    );

    logic an_onehot;
    assign an_onehot = (an_s == 4'b1110) || (an_s == 4'b1101) ||
                       (an_s == 4'b1011) || (an_s == 4'b0111);

    cap_state_e       state_q, state_d;
    logic [3:0]       an_prev_q, an_prev_d;
    logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
    logic             capture;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        an_prev_d    = an_s;
        capture      = 1'b0;
        if (!an_onehot) begin
            state_d      = IDLE;
            settle_cnt_d = '0;
        end else if (an_s != an_prev_q || state_q == IDLE) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
        end else if (state_q == SETTLE) begin
            if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) begin
                capture      = 1'b1;
                state_d      = HOLD;
                settle_cnt_d = '0;
            end else begin
                settle_cnt_d = settle_cnt_q + 1'b1;
            end
        end
    end

    slot_t [3:0]      slot_q, slot_d, prev_q, prev_d;
    logic [3:0]       seen_q, seen_d;
    logic [STW-1:0]   stable_q, stable_d;
    logic [TOW-1:0]   idle_q, idle_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       dp_out_q, dp_out_d;
    logic [3:0]       digit_err_q, digit_err_d;
    logic             frame_valid_q, frame_valid_d;
    logic [1:0]       cap_idx;

    assign cap_idx = anode_idx(an_s);

    // Frame completion is evaluated on the capture cycle itself so the
    // published outputs land exactly one cycle after the fourth capture.
    always_comb begin
        slot_d        = slot_q;
        prev_d        = prev_q;
        seen_d        = seen_q;
        stable_d      = stable_q;
        idle_d        = idle_q;
        timeout_d     = timeout_q;
        digits_d      = digits_q;
        dp_out_d      = dp_out_q;
        digit_err_d   = digit_err_q;
        frame_valid_d = 1'b0;
        if (capture) begin
            slot_d[cap_idx] = '{code: dec_code, dp: ~dp_s, err: dec_err};
            seen_d[cap_idx] = 1'b1;
            idle_d          = '0;
            timeout_d       = 1'b0;
            if (&seen_d) begin
                seen_d = '0;
                if (slot_d == prev_q)
                    stable_d = (stable_q >= STW'(STABLE_FRAMES)) ? stable_q : stable_q + 1'b1;
                else
                    stable_d = STW'(1);
                prev_d = slot_d;
                if (stable_d >= STW'(STABLE_FRAMES)) begin
                    frame_valid_d = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        digits_d[4*k +: 4] = slot_d[k].code;
                        dp_out_d[k]        = slot_d[k].dp;
                        digit_err_d[k]     = slot_d[k].err;
                    end
                end
            end
        end else begin
            if (idle_q != TOW'(TIMEOUT_CYCLES))
                idle_d = idle_q + 1'b1;
            // A dead scan drops any partial frame and stability history.
            if (idle_d == TOW'(TIMEOUT_CYCLES)) begin
                timeout_d = 1'b1;
                seen_d    = '0;
                stable_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            an_prev_q     <= 4'hF;
            settle_cnt_q  <= '0;
            slot_q        <= '{default: '{code: BCD_BLANK, dp: 1'b0, err: 1'b0}};
            prev_q        <= '{default: '{code: BCD_BLANK, dp: 1'b0, err: 1'b0}};
            seen_q        <= '0;
            stable_q      <= '0;
            idle_q        <= '0;
            timeout_q     <= 1'b0;
            digits_q      <= 16'hFFFF;
            dp_out_q      <= '0;
            digit_err_q   <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            an_prev_q     <= an_prev_d;
            settle_cnt_q  <= settle_cnt_d;
            slot_q        <= slot_d;
            prev_q        <= prev_d;
            seen_q        <= seen_d;
            stable_q      <= stable_d;
            idle_q        <= idle_d;
            timeout_q     <= timeout_d;
            digits_q      <= digits_d;
            dp_out_q      <= dp_out_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign digits       = digits_q;
    assign dp_out       = dp_out_q;
    assign digit_err    = digit_err_q;
    assign frame_err    = |digit_err_q;
    assign frame_valid  = frame_valid_q;
    assign scan_timeout = timeout_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed + randomized bench for sseg_scan_capture (default build, no input
// synchronizer) against a frame-level reference model.
module tb_sseg_scan_capture;

    localparam int S  = 16;
    localparam int ST = 2;
    localparam int T  = 500;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an_in;
    logic [6:0]  sseg_in;
    logic        dp_in;
    logic [15:0] digits;
    logic [3:0]  dp_out, digit_err;
    logic        frame_err, frame_valid, scan_timeout;

    sseg_scan_capture #(
        .SETTLE_CYCLES  (S),
        .STABLE_FRAMES  (ST),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .an_in        (an_in),
        .sseg_in      (sseg_in),
        .dp_in        (dp_in),
        .digits       (digits),
        .dp_out       (dp_out),
        .digit_err    (digit_err),
        .frame_err    (frame_err),
        .frame_valid  (frame_valid),
        .scan_timeout (scan_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pulses = 0;
    int last_pulse = -1;
    always @(negedge clk) begin
        if (frame_valid) begin
            pulses     <= pulses + 1;
            last_pulse <= cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, observed cycle %0d required < 200000", cyc);
        $fatal(1, "watchdog");
    end

    // Reference segment table, written from the digit drawings (g..a, active low).
    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int n_tot = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]  m_code [4];
    logic        m_dp   [4];
    logic [3:0]  m_pcode[4];
    logic        m_pdp  [4];
    logic [3:0]  m_seen;
    int          m_stable;
    logic [15:0] m_digits;
    logic [3:0]  m_dpo, m_err;
    int          m_pulses = 0;
    int          m_pulse_cyc = -1;
    int          m_last_cap = 0;

    function automatic logic [3:0] m_dec(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (s == pat[i]) return 4'(i);
        if (s == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    task automatic m_reset();
        m_seen = '0; m_stable = 0;
        m_digits = 16'hFFFF; m_dpo = '0; m_err = '0;
    endtask

    task automatic m_capture(input int k, input logic [6:0] seg, input logic dp, input int c0);
        logic eq;
        m_code[k] = m_dec(seg);
        m_dp[k]   = !dp;
        m_seen[k] = 1'b1;
        m_last_cap = c0 + S;
        if (m_seen == 4'hF) begin
            eq = 1'b1;
            for (int j = 0; j < 4; j++)
                if (m_code[j] != m_pcode[j] || m_dp[j] != m_pdp[j]) eq = 1'b0;
            m_stable = eq ? ((m_stable < ST) ? m_stable + 1 : ST) : 1;
            for (int j = 0; j < 4; j++) begin m_pcode[j] = m_code[j]; m_pdp[j] = m_dp[j]; end
            m_seen = '0;
            if (m_stable >= ST) begin
                for (int j = 0; j < 4; j++) begin
                    m_digits[4*j +: 4] = m_code[j];
                    m_dpo[j] = m_dp[j];
                    m_err[j] = (m_code[j] == 4'hE);
                end
                m_pulses++;
                m_pulse_cyc = c0 + S + 1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Anode stays put for cycles c0..c0+len-1; it needs S+1 stable cycles to be captured.
    task automatic hold(input int k, input logic [6:0] seg, input logic dp, input int len);
        logic [3:0] one;
        int c0;
        one = 4'b0001;
        an_in = ~(one << k); sseg_in = seg; dp_in = dp;
        c0 = cyc;
        repeat (len) @(negedge clk);
        if (len >= S + 1) m_capture(k, seg, dp, c0);
    endtask

    task automatic scan(input logic [3:0][6:0] segs, input logic [3:0] dpn, input int len);
        for (int k = 3; k >= 0; k--) hold(k, segs[k], dpn[k], len);
    endtask

    task automatic gap(input int n);
        an_in = 4'hF; sseg_in = 7'h7F; dp_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; an_in = 4'hF; sseg_in = 7'h7F; dp_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reset();
        m_last_cap = cyc;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pulses"},    pulses,       m_pulses);
        chk({tag, ".digits"},    digits,       m_digits);
        chk({tag, ".dp_out"},    dp_out,       m_dpo);
        chk({tag, ".digit_err"}, digit_err,    m_err);
        chk({tag, ".frame_err"}, frame_err,    |m_err);
        chk({tag, ".timeout"},   scan_timeout, 1'b0);
    endtask

    function automatic logic [3:0][6:0] mk(input int d3, input int d2, input int d1, input int d0);
        logic [3:0][6:0] r;
        r[3] = pat[d3]; r[2] = pat[d2]; r[1] = pat[d1]; r[0] = pat[d0];
        return r;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [3:0][6:0] f;
        int base, c0, lens[6];
        lens = '{10, 16, 17, 18, 25, 40};
        reset = 1'b1; an_in = 4'hF; sseg_in = 7'h7F; dp_in = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all("reset");
        chk("reset.frame_valid", frame_valid, 1'b0);

        // Holds of 10 and exactly S cycles never capture.
        scan(mk(1, 2, 3, 4), 4'hF, 10);
        scan(mk(1, 2, 3, 4), 4'hF, 10);
        scan(mk(1, 2, 3, 4), 4'hF, S);
        scan(mk(1, 2, 3, 4), 4'hF, S);
        gap(2);
        chk_all("short");
        chk("short.digits_const", digits, 16'hFFFF);

        // "12.34": publish after the second matching frame.
        scan(mk(1, 2, 3, 4), 4'b1011, 40);
        gap(2);
        chk_all("1234.first");
        scan(mk(1, 2, 3, 4), 4'b1011, 40);
        gap(2);
        chk_all("1234.second");
        chk("1234.digits_const", digits, 16'h1234);
        chk("1234.dp_const", dp_out, 4'b0100);
        chk("1234.pulse_cyc", last_pulse, m_pulse_cyc);

        // Undecodable digit 1.
        f = mk(5, 6, 0, 9); f[1] = 7'b1010101;
        scan(f, 4'hF, 30); scan(f, 4'hF, 30);
        gap(2);
        chk_all("err");
        chk("err.digit1", digits[7:4], 4'hE);
        chk("err.digit_err_const", digit_err, 4'b0010);
        chk("err.frame_err_const", frame_err, 1'b1);

        // Alternating frames never reach stability; repeating one does.
        do_reset();
        chk_all("alt.reset");
        base = pulses;
        for (int i = 0; i < 2; i++) begin
            scan(mk(0, 0, 0, 0), 4'hF, 20);
            scan(mk(0, 0, 0, 1), 4'hF, 20);
        end
        gap(2);
        chk("alt.no_pulse", pulses - base, 0);
        scan(mk(0, 0, 0, 1), 4'hF, 20);
        gap(2);
        chk_all("alt.repeat");
        chk("alt.one_pulse", pulses - base, 1);
        chk("alt.digits_const", digits, 16'h0001);

        // Timeout: asserted T+1 cycles after the last capture, cleared by the next capture.
        while (cyc < m_last_cap + T) @(negedge clk);
        chk("to.before", scan_timeout, 1'b0);
        @(negedge clk);
        chk("to.asserted", scan_timeout, 1'b1);
        chk("to.digits_kept", digits, m_digits);
        m_seen = '0; m_stable = 0;
        an_in = 4'b1110; sseg_in = pat[8]; dp_in = 1'b1;
        c0 = cyc;
        repeat (S) @(negedge clk);
        chk("to.pre_capture", scan_timeout, 1'b1);
        @(negedge clk);
        chk("to.cleared", scan_timeout, 1'b0);
        repeat (40 - S - 1) @(negedge clk);
        m_capture(0, pat[8], 1'b1, c0);

        // Publish 5678, then reset after two more captures.
        for (int i = 0; i < 3; i++) scan(mk(5, 6, 7, 8), 4'hF, 30);
        gap(2);
        chk_all("pre_rst");
        hold(3, pat[5], 1'b1, 30);
        hold(2, pat[6], 1'b1, 30);
        do_reset();
        @(negedge clk);
        chk_all("midrst");
        chk("midrst.digits_const", digits, 16'hFFFF);
        base = pulses;
        hold(1, pat[7], 1'b1, 30);
        hold(0, pat[8], 1'b1, 30);
        scan(mk(5, 6, 7, 8), 4'hF, 30);
        gap(2);
        chk_all("midrst.f1");
        chk("midrst.no_pulse", pulses - base, 0);
        scan(mk(5, 6, 7, 8), 4'hF, 30);
        gap(2);
        chk_all("midrst.f2");
        chk("midrst.pulse", pulses - base, 1);

        // Random frames with mixed hold lengths; digit 0 always captures to keep the scan alive.
        for (int fr = 0; fr < 8; fr++) begin
            logic [3:0] dpn;
            int np;
            for (int k = 0; k < 4; k++) begin
                int sel;
                sel = $urandom_range(0, 11);
                f[k] = (sel < 10) ? pat[sel] : (sel == 10) ? 7'h7F : 7'($urandom);
            end
            dpn = 4'($urandom);
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                for (int k = 3; k >= 1; k--) hold(k, f[k], dpn[k], lens[$urandom_range(0, 5)]);
                hold(0, f[0], dpn[0], 40);
                gap(2);
                chk_all($sformatf("rnd%0d.%0d", fr, p));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
